// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time over
// req/gnt/rvalid, and hands each fetched word to decode over valid/ready.
// Redirects retarget the PC; a response that was already in flight when a
// redirect arrives is swallowed via the drop flag. A misaligned redirect
// target parks the stage in HALT until reset.
module ifu_fetch #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              fetch_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop, drop_nxt;
    logic            vld_nxt;
    logic            mis_nxt;
    logic            capture;
    logic            redir_ok;
    logic            redir_bad;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    // Next-state logic; redirect outranks everything except HALT.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        vld_nxt   = inst_valid;
        mis_nxt   = fetch_misaligned;
        capture   = 1'b0;
        if (state != S_HALT) begin
            if (redir_bad) begin
                mis_nxt   = 1'b1;
                vld_nxt   = 1'b0;
                state_nxt = S_HALT;
            end else begin
                if (redir_ok) begin
                    pc_nxt  = redirect_pc;
                    vld_nxt = 1'b0;
                end
                case (state)
                    S_IDLE: state_nxt = S_REQ;
                    S_REQ: begin
                        // Old address accepted alongside a redirect: its data must be dropped.
                        if (imem_gnt) begin
                            state_nxt = S_WAIT;
                            drop_nxt  = redir_ok;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (!drop && !redir_ok) begin
                                capture   = 1'b1;
                                pc_nxt    = pc + XLEN'(4);
                                vld_nxt   = 1'b1;
                                state_nxt = S_HOLD;
                            end else begin
                                drop_nxt  = 1'b0;
                                state_nxt = S_REQ;
                            end
                        end else if (redir_ok) begin
                            drop_nxt = 1'b1;
                        end
                    end
                    S_HOLD: begin
                        // A redirect flushes the held word even if decode takes it.
                        if (redir_ok || inst_ready) begin
                            vld_nxt   = 1'b0;
                            state_nxt = S_REQ;
                        end
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // State, PC and control flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            drop             <= 1'b0;
            inst_valid       <= 1'b0;
            fetch_misaligned <= 1'b0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            drop             <= drop_nxt;
            inst_valid       <= vld_nxt;
            fetch_misaligned <= mis_nxt;
        end
    end

    // Instruction register toward decode; only loaded on a live response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (capture) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level fetch model plus randomized memory,
// decode and redirect stimulus, with directed scenarios pinned by literals.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_misaligned(fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    // stimulus knobs (percentages / latency bounds) and one-shot overrides
    int          p_gnt = 100, p_rdy = 100, p_redir = 0, p_mis = 0, p_spur = 0;
    int          lat_min = 1, lat_max = 1;
    bit          f_redir = 0;
    logic [31:0] f_rpc = '0;
    bit          f_data_en = 0;
    logic [31:0] f_data = '0;
    bit          saw_dead = 0;

    // memory responder
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = '0;

    // behavioural model: what the fetch unit is doing, in transaction terms
    logic [31:0] m_pc;
    bit          m_boot, m_infl, m_stale, m_have, m_halt, m_mis;
    logic [31:0] m_inst, m_ipc;
    int          halt_cnt = 0;

    // trace of the first cycles after a reset release
    logic        rec_req [0:15];
    logic [31:0] rec_addr[0:15];
    logic        rec_vld [0:15];
    logic [31:0] rec_ipc [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_req();
        return !m_halt && !m_boot && !m_infl && !m_have;
    endfunction

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_boot = 1; m_infl = 0; m_stale = 0;
        m_have = 0; m_halt = 0; m_mis = 0; m_inst = '0; m_ipc = '0;
    endtask

    task automatic model_step(input bit rv, input logic [31:0] rd, input bit gnt,
                              input bit rdy, input bit redir, input logic [31:0] rpc);
        bit req;
        req = m_req();
        if (m_halt) return;
        if (redir && rpc[1:0] != 2'b00) begin
            m_halt = 1; m_mis = 1; m_have = 0;
            return;
        end
        if (redir) begin
            m_pc = rpc; m_have = 0; m_boot = 0;
            if (req && gnt) begin
                m_infl = 1; m_stale = 1;
            end else if (m_infl) begin
                if (rv) begin m_infl = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else if (m_boot) begin
            m_boot = 0;
        end else if (req && gnt) begin
            m_infl = 1; m_stale = 0;
        end else if (m_infl && rv) begin
            m_infl = 0;
            if (!m_stale) begin
                m_have = 1; m_inst = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
            end
            m_stale = 0;
        end else if (m_have && rdy) begin
            m_have = 0;
        end
    endtask

    // One clock: compare outputs, drive new inputs, advance model and memory.
    task automatic cycle();
        bit          rv, gnt, rdy, redir;
        logic [31:0] rd, rpc;
        int          idx;
        chk("req", imem_req, m_req());
        chk("addr", imem_addr, m_pc);
        chk("valid", inst_valid, m_have);
        chk("misaligned", fetch_misaligned, m_mis);
        if (m_have) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_ipc);
        end
        if (inst_valid && inst == 32'hDEAD_BEEF) saw_dead = 1;
        idx = cyc - base;
        if (idx >= 0 && idx < 16) begin
            rec_req[idx] = imem_req; rec_addr[idx] = imem_addr;
            rec_vld[idx] = inst_valid; rec_ipc[idx] = inst_pc;
        end
        halt_cnt = m_halt ? halt_cnt + 1 : 0;

        rv = mem_busy && mem_cnt == 0;
        rd = rv ? mem_data : $urandom;
        if (!mem_busy && $urandom_range(99) < p_spur) begin
            rv = 1; rd = $urandom;
        end
        gnt = $urandom_range(99) < p_gnt;
        rdy = $urandom_range(99) < p_rdy;
        redir = 0; rpc = $urandom;
        if (f_redir) begin
            redir = 1; rpc = f_rpc; f_redir = 0;
        end else if ($urandom_range(99) < p_redir) begin
            redir = 1;
            if ($urandom_range(99) >= p_mis) rpc[1:0] = 2'b00;
            else if (rpc[1:0] == 2'b00) rpc[0] = 1'b1;
        end
        imem_rvalid = rv; imem_rdata = rd; imem_gnt = gnt; inst_ready = rdy;
        redirect_valid = redir; redirect_pc = rpc;

        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (imem_req && gnt) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
            mem_data = f_data_en ? f_data : $urandom;
        end
        model_step(rv, rd, gnt, rdy, redir, rpc);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; inst_ready = 0;
        mem_busy = 0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_mis", fetch_misaligned, 0);
        chk("rst_addr", imem_addr, 32'h8000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        base = cyc;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) cycle();
        chk(name, inst_valid, 1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40 && imem_req !== 1'b1; i++) cycle();
        chk(name, imem_req, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc, held_inst;
        rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // ideal memory, decode always ready
        repeat (12) cycle();
        chk("t1_idle_req", rec_req[0], 0);
        chk("t1_first_req", rec_req[1], 1);
        chk("t1_first_addr", rec_addr[1], 32'h8000_0000);
        chk("t1_v3", rec_vld[3], 1);
        chk("t1_pc3", rec_ipc[3], 32'h8000_0000);
        chk("t1_v4", rec_vld[4], 0);
        chk("t1_v6", rec_vld[6], 1);
        chk("t1_pc6", rec_ipc[6], 32'h8000_0004);
        chk("t1_v9", rec_vld[9], 1);
        chk("t1_pc9", rec_ipc[9], 32'h8000_0008);

        // backpressure
        p_rdy = 0;
        wait_valid("t2_valid");
        held_pc = inst_pc; held_inst = inst;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_pc", inst_pc, held_pc);
            chk("t2_hold_inst", inst, held_inst);
            chk("t2_no_req", imem_req, 0);
            cycle();
        end
        p_rdy = 100;
        cycle();
        chk("t2_next_req", imem_req, 1);
        chk("t2_next_addr", imem_addr, held_pc + 32'd4);

        // redirect while waiting for a slow response
        f_data_en = 1; f_data = 32'hDEAD_BEEF; lat_min = 3; lat_max = 3;
        wait_req("t3_req");
        cycle();
        f_data_en = 0; lat_min = 1; lat_max = 1;
        f_redir = 1; f_rpc = 32'h8000_0100;
        cycle();
        wait_req("t3_retarget_req");
        chk("t3_addr", imem_addr, 32'h8000_0100);
        wait_valid("t3_valid");
        chk("t3_inst_pc", inst_pc, 32'h8000_0100);
        chk("t3_stale_word", saw_dead, 0);
        cycle();

        // redirect in HOLD together with inst_ready
        p_rdy = 0;
        wait_valid("t4_valid");
        f_redir = 1; f_rpc = 32'h8000_0200; p_rdy = 100;
        cycle();
        chk("t4_valid_drop", inst_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h8000_0200);
        wait_valid("t4_valid2");
        chk("t4_inst_pc", inst_pc, 32'h8000_0200);
        cycle();

        // pc wrap
        f_redir = 1; f_rpc = 32'hFFFF_FFFC;
        cycle();
        wait_valid("t5_valid");
        chk("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
        cycle();
        wait_valid("t5_valid2");
        chk("t5_pc_wrap", inst_pc, 32'h0000_0000);
        cycle();

        // misaligned redirect halts until reset
        f_redir = 1; f_rpc = 32'h8000_0102;
        cycle();
        chk("t6_mis", fetch_misaligned, 1);
        p_redir = 30; p_gnt = 60; p_spur = 20;
        for (int i = 0; i < 22; i++) begin
            chk("t6_halt_req", imem_req, 0);
            chk("t6_halt_valid", inst_valid, 0);
            cycle();
        end
        chk("t6_mis_sticky", fetch_misaligned, 1);
        p_redir = 0; p_gnt = 100; p_spur = 0;
        do_reset();
        cycle();
        chk("t6_restart_req", imem_req, 1);
        chk("t6_restart_addr", imem_addr, 32'h8000_0000);

        // randomized traffic
        p_gnt = 60; p_rdy = 60; p_redir = 8; p_mis = 5; p_spur = 10;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (i % 500 == 499 || halt_cnt > 25) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage of the single-issue RV32 core; sits directly upstream of the instruction decoder.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake with variable latency.
- Presents each fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) from downstream.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
- XLEN, 32, address and data width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals the internal pc.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response data valid; arrives at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc hold a valid instruction for decode.
- inst  out  32  registered instruction word to decode.
- inst_pc  out  XLEN  PC of inst.
- inst_ready  in  1  decode consumes inst this cycle when inst_valid=1.
- redirect_valid  in  1  replace the PC with redirect_pc.
- redirect_pc  in  XLEN  new fetch target.
- fetch_misaligned  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - pc=RESET_PC, state=IDLE, drop=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_misaligned=0.
- States: IDLE, REQ, WAIT, HOLD, HALT.
- Outputs: imem_req=1 only in REQ; imem_addr=pc in every state.
- IDLE: always moves to REQ next cycle. The first request is therefore driven in the 2nd cycle after rst_n rises.
- REQ:
  - imem_req=1.
  - imem_gnt=1 -> WAIT.
  - Otherwise hold REQ with imem_addr unchanged; a redirect is the only exception.
- WAIT:
  - imem_rvalid=1 and drop=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, -> HOLD.
  - imem_rvalid=1 and drop=1: discard data, drop<=0, -> REQ.
  - Responses seen in any state other than WAIT are ignored.
- HOLD:
  - inst_valid=1.
  - inst_ready=1: inst_valid<=0 -> REQ.
  - inst_ready=0: inst and inst_pc remain stable.
- Throughput and latency:
  - At most one request is outstanding; no prefetch.
  - Minimum request-to-inst_valid latency is 2 cycles (gnt in cycle N, rvalid in N+1, inst_valid in N+2).
  - Peak rate is 1 instruction per 3 cycles.
- pc arithmetic: pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0); no fault on wrap.
- Redirect (redirect_valid=1) has the highest priority in every state except HALT:
  - redirect_pc[1:0] != 0: fetch_misaligned<=1, inst_valid<=0, -> HALT.
  - Otherwise pc<=redirect_pc and inst_valid<=0.
  - Next state when the target is aligned:
    - REQ without gnt: stay in REQ; the request is retargeted next cycle.
    - REQ with gnt in the same cycle: drop<=1, -> WAIT, because the old address was accepted.
    - WAIT without rvalid: drop<=1, stay in WAIT.
    - WAIT with rvalid in the same cycle: discard the data, drop<=0, -> REQ.
    - HOLD: -> REQ. This applies even if inst_ready=1 in the same cycle: the held instruction counts as flushed and decode must ignore it.
    - IDLE: pc is updated and the state goes to REQ normally.
- HALT: no requests, inst_valid=0, all inputs ignored; only reset exits. fetch_misaligned stays 1 until reset.
- Reset mid-operation: returns immediately to reset values. A memory response still outstanding after reset is ignored because the state is not WAIT.

Test Plan:
- Reset release, 1-cycle memory (gnt same cycle as req, rvalid next cycle), inst_ready tied 1 -> first imem_addr=32'h8000_0000; inst_pc sequence 8000_0000, 8000_0004, 8000_0008, with one instruction every 3 cycles.
- Backpressure: inst_ready=0 for 5 cycles with inst_valid=1 -> inst and inst_pc stable, imem_req=0 throughout; fetch of pc+4 begins the cycle after inst_ready=1.
- Redirect while in WAIT to 32'h8000_0100, then the stale rvalid with data 32'hDEAD_BEEF -> stale word never appears on inst; next request addr=8000_0100; next inst_pc=8000_0100.
- Redirect in HOLD in the same cycle as inst_ready=1 -> inst_valid=0 next cycle; next fetch addr=redirect_pc.
- Redirect to 32'h8000_0102 -> fetch_misaligned=1; imem_req stays 0 for 20+ cycles; asynchronous rst_n pulse clears the flag and fetch restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC -> fetched inst_pc values FFFF_FFFC then 0000_0000.
